imem_loader: RTL and testbench

- Writer-side counterpart to the instruction memory: fills imem at boot from an external byte stream (UART/debug bridge).
- Assembles little-endian bytes into 32-bit words and issues single-cycle word writes at word-aligned byte addresses, matching the imem read-address convention (word index = addr[31:2]).
- Holds the core in reset (core_hold_o) while a load is in progress.

---
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: turns a little-endian byte stream
// (length header, then payload words) into word-aligned imem writes.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        busy_o,
  output logic        core_hold_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] words_loaded_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic [31:0] len;
  logic [31:0] word_idx;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        handshake;
  logic        last_byte;
  logic        start_ok;
  logic [31:0] assembled;
  logic [31:0] next_idx;

  // The fourth byte is never stored in partial; it is merged on the fly.
  assign handshake = byte_valid_i && byte_ready_o;
  assign last_byte = handshake && (byte_cnt == 2'd3);
  assign start_ok  = start_i && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign assembled = {byte_data_i, partial};
  assign next_idx  = word_idx + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      partial  <= 24'd0;
      len      <= 32'd0;
      word_idx <= 32'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      if (handshake) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    partial[7:0]   <= byte_data_i;
          2'd1:    partial[15:8]  <= byte_data_i;
          2'd2:    partial[23:16] <= byte_data_i;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= LEN;
            byte_cnt <= 2'd0;
          end
        end
        LEN: begin
          if (last_byte) begin
            len <= assembled;
            if (assembled == 32'd0)
              state <= DONE;
            else if (assembled > 32'(DEPTH))
              state <= ERR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (last_byte) begin
            wdata_q <= assembled;
            addr_q  <= BASE_ADDR + {word_idx[29:0], 2'b00};
            state   <= WRITE;
          end
        end
        WRITE: begin
          word_idx <= next_idx;
          state    <= (next_idx == len) ? DONE : DATA;
        end
        DONE, ERR: begin
          if (start_ok) begin
            state    <= LEN;
            byte_cnt <= 2'd0;
            word_idx <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready drops in the write cycle so only one word is ever in flight.
  assign byte_ready_o   = (state == LEN) || (state == DATA);
  assign mem_we_o       = (state == WRITE);
  assign busy_o         = (state == LEN) || (state == DATA) || (state == WRITE);
  assign core_hold_o    = busy_o;
  assign done_o         = (state == DONE);
  assign err_o          = (state == ERR);
  assign words_loaded_o = word_idx;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are
// streamed in and retired by a monitor as mem_we_o pulses appear.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        sel;

  logic        start_a, ready_a, we_a, busy_a, hold_a, done_a, err_a;
  logic [31:0] addr_a, wdata_a, wl_a;
  logic        start_b, ready_b, we_b, busy_b, hold_b, done_b, err_b;
  logic [31:0] addr_b, wdata_b, wl_b;

  logic        ready_m, we_m, busy_m, hold_m, done_m, err_m;
  logic [31:0] addr_m, wdata_m, wl_m;

  wr_t         exp_q[$];
  wr_t         exp_wr;
  int          total = 0;
  int          bad = 0;
  int          write_count = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  // Instance a is the default-sized memory, instance b the tiny offset one;
  // they share the byte stream and reset, start only reaches the selected one.
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  imem_loader dut_a (
    .clk(clk), .rst(rst), .start_i(start_a),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .byte_ready_o(ready_a), .mem_we_o(we_a), .mem_addr_o(addr_a),
    .mem_wdata_o(wdata_a), .busy_o(busy_a), .core_hold_o(hold_a),
    .done_o(done_a), .err_o(err_a), .words_loaded_o(wl_a)
  );

  imem_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_0100)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .byte_ready_o(ready_b), .mem_we_o(we_b), .mem_addr_o(addr_b),
    .mem_wdata_o(wdata_b), .busy_o(busy_b), .core_hold_o(hold_b),
    .done_o(done_b), .err_o(err_b), .words_loaded_o(wl_b)
  );

  assign ready_m = sel ? ready_b : ready_a;
  assign we_m    = sel ? we_b    : we_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign hold_m  = sel ? hold_b  : hold_a;
  assign done_m  = sel ? done_b  : done_a;
  assign err_m   = sel ? err_b   : err_a;
  assign addr_m  = sel ? addr_b  : addr_a;
  assign wdata_m = sel ? wdata_b : wdata_a;
  assign wl_m    = sel ? wl_b    : wl_a;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Every cycle: ready must be high exactly when busy and not writing, and
  // each write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("ready_rule", 32'(ready_m), 32'(busy_m & ~we_m));
      checkOutput("hold_eq_busy", 32'(hold_m), 32'(busy_m));
      if (we_m === 1'b1) begin
        write_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", addr_m, 32'hFFFF_FFFF);
        end else begin
          exp_wr = exp_q.pop_front();
          checkOutput("wr_addr", addr_m, exp_wr.addr);
          checkOutput("wr_data", wdata_m, exp_wr.data);
        end
      end else if (we_m !== 1'b0) begin
        checkOutput("we_known", 32'(we_m), 32'd0);
      end
    end
  end

  // Called and returning on a falling edge; gives up after a bounded wait.
  task automatic applyStimulus(input logic [7:0] b, input int max_gap);
    int guard;
    bit ok;
    if (max_gap > 0) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    ok = 1'b0;
    do begin
      ok = ready_m;
      @(negedge clk);
      guard++;
    end while (!ok && guard < 64);
    byte_valid = 1'b0;
    checkOutput("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic sendHeader(input logic [31:0] n, input int max_gap);
    for (int i = 0; i < 4; i++) applyStimulus(n[8*i +: 8], max_gap);
  endtask

  task automatic sendWord(input logic [31:0] w, input logic [31:0] addr, input int max_gap);
    exp_q.push_back('{addr: addr, data: w});
    for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], max_gap);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready_m), 32'd0);
    checkOutput("rst_we", 32'(we_m), 32'd0);
    checkOutput("rst_addr", addr_m, 32'd0);
    checkOutput("rst_wdata", wdata_m, 32'd0);
    checkOutput("rst_busy", 32'(busy_m), 32'd0);
    checkOutput("rst_hold", 32'(hold_m), 32'd0);
    checkOutput("rst_done", 32'(done_m), 32'd0);
    checkOutput("rst_err", 32'(err_m), 32'd0);
    checkOutput("rst_words", wl_m, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (done_m !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_wait", 32'(done_m), 32'd1);
  endtask

  task automatic settleAndCount(input string tag, input int want);
    repeat (2) @(negedge clk);
    checkOutput(tag, 32'(write_count), 32'(want));
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; sel = 1'b0;
    doReset();

    // Basic two-word load with the exact bytes from the bring-up note.
    write_count = 0;
    pulseStart();
    checkOutput("len_busy", 32'(busy_m), 32'd1);
    sendHeader(32'd2, 0);
    sendWord(32'h0010_0513, 32'h0, 0);
    sendWord(32'h0000_006F, 32'h4, 0);
    checkOutput("basic_done_t1", 32'(done_m), 32'd0);
    @(negedge clk);
    checkOutput("basic_done_t2", 32'(done_m), 32'd1);
    checkOutput("basic_hold", 32'(hold_m), 32'd0);
    checkOutput("basic_words", wl_m, 32'd2);
    settleAndCount("basic_writes", 2);

    // Zero-length header completes immediately with no writes.
    write_count = 0;
    pulseStart();
    checkOutput("restart_done_clr", 32'(done_m), 32'd0);
    checkOutput("restart_words_clr", wl_m, 32'd0);
    sendHeader(32'd0, 0);
    checkOutput("zero_done", 32'(done_m), 32'd1);
    checkOutput("zero_words", wl_m, 32'd0);
    settleAndCount("zero_writes", 0);

    // Oversize header lands in ERR; presented bytes are ignored.
    write_count = 0;
    pulseStart();
    sendHeader(32'd1025, 0);
    checkOutput("over_err", 32'(err_m), 32'd1);
    checkOutput("over_busy", 32'(busy_m), 32'd0);
    checkOutput("over_done", 32'(done_m), 32'd0);
    byte_valid = 1'b1; byte_data = 8'hA5;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    checkOutput("over_err_sticky", 32'(err_m), 32'd1);
    pulseStart();
    checkOutput("over_err_clr", 32'(err_m), 32'd0);
    checkOutput("over_relen_busy", 32'(busy_m), 32'd1);
    sendHeader(32'd1, 0);
    sendWord(32'hDEAD_BEEF, 32'h0, 0);
    waitDone(4);
    settleAndCount("over_writes", 1);

    // Random source gaps must not change what gets written.
    write_count = 0;
    pulseStart();
    sendHeader(32'd3, 3);
    sendWord(32'h1234_5678, 32'h0, 3);
    sendWord(32'h9ABC_DEF0, 32'h4, 3);
    sendWord(32'h0F1E_2D3C, 32'h8, 3);
    waitDone(8);
    checkOutput("gap_words", wl_m, 32'd3);
    settleAndCount("gap_writes", 3);

    // Reset in the middle of word 1 drops the partial word.
    write_count = 0;
    pulseStart();
    sendHeader(32'd3, 0);
    sendWord(32'hCAFE_F00D, 32'h0, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    doReset();
    settleAndCount("midrst_writes", 1);
    write_count = 0;
    pulseStart();
    sendHeader(32'd1, 0);
    sendWord(32'h5555_AAAA, 32'h0, 0);
    waitDone(4);
    checkOutput("midrst_words", wl_m, 32'd1);
    settleAndCount("midrst_fresh_writes", 1);

    // Reset beats a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("rst_wins_done", 32'(done_m), 32'd0);
    @(negedge clk);
    checkOutput("rst_wins_busy", 32'(busy_m), 32'd0);

    // Full-depth load on the small offset instance, with a stray start.
    sel = 1'b1;
    write_count = 0;
    pulseStart();
    sendHeader(32'd4, 0);
    sendWord(32'h0000_0001, 32'h100, 0);
    sendWord(32'h0000_0002, 32'h104, 0);
    @(negedge clk);
    pulseStart();
    checkOutput("full_start_ignored", 32'(busy_m), 32'd1);
    checkOutput("full_mid_words", wl_m, 32'd2);
    sendWord(32'h0000_0003, 32'h108, 0);
    sendWord(32'hFFFF_FFFF, 32'h10C, 0);
    waitDone(4);
    checkOutput("full_words", wl_m, 32'd4);
    checkOutput("full_last_addr", addr_m, 32'h0000_010C);
    settleAndCount("full_writes", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
